// File: rtl/mdr_mem_interface_pkg.sv
// Shared datapath definitions for the MDR/MAR memory interface: word width,
// parameter defaults and the access FSM state encoding.
package mdr_mem_interface_pkg;

    localparam int WORD_W      = 32;
    localparam int ADDR_W_DEF  = 9;
    localparam int TIMEOUT_DEF = 15;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_RD_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_WR_WAIT = 2'd2;

endpackage

// File: rtl/mdr_mem_interface_access_timer.sv
// Wait-cycle counter for one memory access. The counter sits at zero while no
// access is outstanding, so it is already clear on the first wait cycle, and it
// advances once per wait cycle that sees no acknowledge. expired flags the wait
// cycle in which the TIMEOUT-th un-acknowledged wait cycle is being spent.
module access_timer
    import mdr_mem_interface_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count un-acknowledged wait cycles; hold at zero outside an access.
    always_ff @(posedge clk) begin
        if (clr || !active) begin
            wait_cnt <= '0;
        end else if (!ack && !expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Timeout is decided in the last allowed wait cycle if no ack arrives.
    always_comb begin
        expired = active && !ack && (wait_cnt == LAST);
    end

endmodule

// File: rtl/mdr_mem_interface.sv
// Memory data register (MDR) and memory address register (MAR) with a small
// read/write handshake FSM toward memory. MDR loads either straight from the
// datapath bus or from memory read data; writes send MDR to address MAR.
// Memory handshake: mem_rd/mem_wr are request levels held for the whole wait
// state; an access completes on the first rising edge at which mem_ack is 1
// while the request is high, and is abandoned after TIMEOUT wait cycles.
// Outputs toward memory and the bus come straight from registers.
module mdr_mem_interface
    import mdr_mem_interface_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [WORD_W-1:0]   bus_mux_out,
    input  logic                mar_in,
    input  logic                mdr_in,
    input  logic                read,
    input  logic                write_req,
    input  logic [WORD_W-1:0]   mem_data_in,
    input  logic                mem_ack,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_data_out,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [WORD_W-1:0]   mdr_out,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [STATE_W-1:0]  state_dbg
);

    logic [STATE_W-1:0] state;
    logic [ADDR_W-1:0]  mar;
    logic [WORD_W-1:0]  mdr;
    logic               done_q;
    logic               err_q;
    logic               waiting;
    logic               timed_out;

    assign waiting = (state != ST_IDLE);

    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .clr     (clr),
        .active  (waiting),
        .ack     (mem_ack),
        .expired (timed_out)
    );

    // Access FSM plus MAR/MDR registers and the done/err completion pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= ST_IDLE;
            mar    <= '0;
            mdr    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mar_in) begin
                        mar <= bus_mux_out[ADDR_W-1:0];
                    end
                    // A read request beats a simultaneous write_req, which is dropped.
                    if (mdr_in && !read) begin
                        mdr    <= bus_mux_out;
                        done_q <= 1'b1;
                    end else if (mdr_in && read) begin
                        state <= ST_RD_WAIT;
                    end else if (write_req) begin
                        state <= ST_WR_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_ack) begin
                        mdr    <= mem_data_in;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_WR_WAIT: begin
                    if (mem_ack) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register-driven outputs.
    always_comb begin
        mem_addr     = mar;
        mem_data_out = mdr;
        mdr_out      = mdr;
        mem_rd       = (state == ST_RD_WAIT);
        mem_wr       = (state == ST_WR_WAIT);
        busy         = waiting;
        done         = done_q;
        err          = err_q;
        state_dbg    = state;
    end

endmodule

// File: doc/mdr_mem_interface.md
MDR_MEM_INTERFACE -- requirements
Module: mdr_mem_interface

Interface
REQ-001 Parameter ADDR_W, default 9, word-address width of the memory-address register (MAR).
REQ-002 Parameter TIMEOUT, default 15, maximum cycles to wait for mem_ack before abandoning an access.
REQ-003 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port clr  in  1  reset, synchronous and active-high.
REQ-005 Port bus_mux_out  in  32  shared datapath bus value, the bus multiplexer output.
REQ-006 Port mar_in  in  1  load MAR from bus_mux_out[ADDR_W-1:0].
REQ-007 Port mdr_in  in  1  load MDR from the source selected by read.
REQ-008 Port read  in  1  MDR source select: 1 = memory read, 0 = bus_mux_out.
REQ-009 Port write_req  in  1  start a memory write of MDR to address MAR.
REQ-010 Port mem_data_in  in  32  memory read data.
REQ-011 Port mem_ack  in  1  memory completion strobe for the current access.
REQ-012 Port mem_addr  out  ADDR_W  current MAR value.
REQ-013 Port mem_data_out  out  32  current MDR value.
REQ-014 Port mem_rd / mem_wr  out  1 each  memory read/write request levels.
REQ-015 Port mdr_out  out  32  MDR value, feeding the bus multiplexer MDR input.
REQ-016 Port busy  out  1  high while a memory access is outstanding.
REQ-017 Port done  out  1  one-cycle pulse on completion of any MDR load or memory write.
REQ-018 Port err  out  1  one-cycle pulse on access timeout.

Function
REQ-019 The FSM SHALL have states IDLE, RD_WAIT and WR_WAIT; busy = (state != IDLE).
REQ-020 In IDLE, mdr_in=1 with read=0 SHALL load MDR from bus_mux_out at that edge and pulse done in the next cycle, with no memory access.
REQ-021 In IDLE, mdr_in=1 with read=1 SHALL move to RD_WAIT; mem_rd = 1 exactly while in RD_WAIT.
REQ-022 In IDLE, write_req=1 with no read request SHALL move to WR_WAIT; mem_wr = 1 exactly while in WR_WAIT.
REQ-023 Simultaneous read request and write_req in IDLE: the read wins and write_req is dropped, not queued.
REQ-024 In RD_WAIT, mem_ack=1 SHALL load MDR from mem_data_in, return to IDLE and pulse done in the next cycle.
REQ-025 In WR_WAIT, mem_ack=1 SHALL return to IDLE and pulse done in the next cycle; MDR is unchanged.
REQ-026 A wait-cycle counter SHALL clear on entry to RD_WAIT or WR_WAIT and increment each cycle without mem_ack; if TIMEOUT wait cycles pass without ack, the FSM returns to IDLE, err pulses for one cycle, and MDR is unchanged.
REQ-027 Minimum read latency: request edge T, ack sampled at edge T+1, MDR updated at edge T+1, done high in cycle T+1..T+2.
REQ-028 mar_in SHALL load MAR in IDLE only; mar_in, mdr_in and write_req while busy SHALL be ignored.
REQ-029 mem_ack in IDLE SHALL be ignored.
REQ-030 mem_addr, mem_data_out and mdr_out SHALL be driven directly from registers, with no combinational path from inputs.
REQ-031 done and err SHALL never be high in the same cycle.

Reset
REQ-032 clr=1 at a clock edge SHALL force IDLE, MAR=0, MDR=0, counter=0, and mem_rd, mem_wr, busy, done and err all 0, overriding every other input.
REQ-033 clr asserted mid-access SHALL abandon the access with no done or err pulse; mem_rd or mem_wr is low in the cycle after that edge.

Structure
REQ-034 A shared datapath package SHALL hold the FSM state encoding, the 32-bit word width constant and the ADDR_W/TIMEOUT defaults.
REQ-035 A single sub-module, access_timer (counter plus timeout compare), SHALL be instantiated once; all other logic is flat.

Verification
REQ-036 Bus load: bus_mux_out=0xDEADBEEF, mdr_in=1, read=0 for one cycle -> next cycle mdr_out=0xDEADBEEF, done=1 for one cycle, mem_rd=0.
REQ-037 Memory read: MAR loaded with 0x05, mdr_in=1, read=1; ack after 3 wait cycles with mem_data_in=0x12345678 -> mem_addr=0x05, mem_rd high exactly 3 cycles, mdr_out=0x12345678, one done pulse.
REQ-038 Memory write: MDR=0xA5A5A5A5, MAR=0x1FF, write_req=1, ack on the first wait cycle -> mem_wr high 1 cycle, mem_data_out=0xA5A5A5A5, mem_addr=0x1FF, one done pulse.
REQ-039 Timeout: read request with mem_ack held 0 -> after 15 wait cycles mem_rd drops, err=1 for one cycle, MDR unchanged, done stays 0.
REQ-040 Conflict and busy: read and write_req in the same cycle -> only mem_rd asserted; mar_in with bus_mux_out=0x0AA during RD_WAIT -> MAR unchanged.
REQ-041 Reset mid-access: clr=1 in the second RD_WAIT cycle -> next cycle mem_rd=0, mdr_out=0, busy=0; a later mem_ack has no effect.
